// File: rtl/memwb_if.sv
// rtl/memwb_if.sv - memwb handshake, register-file and data-bus signal bundle
// slave is the memwb view; master is the execute/bus/regfile environment view.
interface memwb_if #(
  parameter int RW    = 16,
  parameter int REGNO = 8
);
  logic             i_submit;
  logic             o_ready;
  logic [RW-1:0]    i_data;
  logic [RW-1:0]    i_addr;
  logic [REGNO-1:0] i_reg_ie;
  logic             i_mem_access;
  logic             i_mem_we;
  logic             o_mem_req;
  logic             o_mem_we;
  logic [RW-1:0]    o_mem_addr;
  logic [RW-1:0]    o_mem_data;
  logic [RW-1:0]    i_mem_data;
  logic             i_mem_ack;
  logic [REGNO-1:0] o_reg_ie;
  logic [RW-1:0]    o_reg_data;
  logic             o_bus_err;

  modport slave (
    input  i_submit, i_data, i_addr, i_reg_ie, i_mem_access, i_mem_we,
    input  i_mem_data, i_mem_ack,
    output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_data,
    output o_reg_ie, o_reg_data, o_bus_err
  );

  modport master (
    output i_submit, i_data, i_addr, i_reg_ie, i_mem_access, i_mem_we,
    output i_mem_data, i_mem_ack,
    input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_data,
    input  o_reg_ie, o_reg_data, o_bus_err
  );
endinterface

// File: rtl/memwb.sv
// rtl/memwb.sv - memory/writeback stage with req/ack data bus
// Optional bus timeout enabled by defining MEMWB_BUS_TIMEOUT_EN.
module memwb #(
  parameter int RW      = 16,
  parameter int REGNO   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic    i_clk,
  input  logic    i_rst,
  memwb_if.slave  bus
);
  typedef enum logic {IDLE, BUS} state_t;

  state_t           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [RW-1:0]    mem_addr_q, mem_addr_d;
  logic [RW-1:0]    mem_data_q, mem_data_d;
  logic [REGNO-1:0] reg_ie_q, reg_ie_d;
  logic [RW-1:0]    reg_data_q, reg_data_d;
  logic [REGNO-1:0] pend_ie_q, pend_ie_d;

`ifdef MEMWB_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`else
  localparam bit unused_timeout_ok = (TIMEOUT >= 1);
`endif

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    reg_ie_d   = '0;
    reg_data_d = reg_data_q;
    pend_ie_d  = pend_ie_q;
`ifdef MEMWB_BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_submit) begin
          if (bus.i_mem_access) begin
            mem_addr_d = bus.i_addr;
            mem_data_d = bus.i_data;
            mem_we_d   = bus.i_mem_we;
            pend_ie_d  = bus.i_reg_ie;
            mem_req_d  = 1'b1;
            state_d    = BUS;
`ifdef MEMWB_BUS_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end else begin
            reg_ie_d   = bus.i_reg_ie;
            reg_data_d = bus.i_data;
          end
        end
      end
      BUS: begin
        // Ack wins over a timeout reached in the same cycle.
        if (bus.i_mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!mem_we_q) begin
            reg_ie_d   = pend_ie_q;
            reg_data_d = bus.i_mem_data;
          end
        end
`ifdef MEMWB_BUS_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      reg_ie_q   <= '0;
      reg_data_q <= '0;
      pend_ie_q  <= '0;
`ifdef MEMWB_BUS_TIMEOUT_EN
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      reg_ie_q   <= reg_ie_d;
      reg_data_q <= reg_data_d;
      pend_ie_q  <= pend_ie_d;
`ifdef MEMWB_BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
`endif
    end
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_mem_req  = mem_req_q;
  assign bus.o_mem_we   = mem_we_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_data = mem_data_q;
  assign bus.o_reg_ie   = reg_ie_q;
  assign bus.o_reg_data = reg_data_q;
`ifdef MEMWB_BUS_TIMEOUT_EN
  assign bus.o_bus_err  = bus_err_q;
`else
  assign bus.o_bus_err  = 1'b0;
`endif
endmodule

// File: doc/memwb.md
Name: memwb

Overview:
- Memory/writeback stage; sits directly downstream of the execute stage.
- Consumes execute's registered result bundle: data, address, register write-enable, mem-access flag, mem-write flag, submit.
- Non-memory results are written to the register file one cycle after acceptance.
- Loads and stores run a req/ack data-bus transaction. Load data is then written back to the register file; o_ready stalls execute while the bus is busy.

Parameters:
- RW, 16, data/address width.
- REGNO, 8, number of registers; width of the one-hot write-enable vector.
- TIMEOUT, 255, bus wait limit in cycles. Used only with MEMWB_BUS_TIMEOUT_EN; must be >= 1.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_submit  in  1  execute presents a valid result this cycle.
- o_ready  out  1  stage can accept; combinational, equals (state == IDLE).
- i_data  in  RW  ALU/sreg result, or store data when i_mem_access=1.
- i_addr  in  RW  memory address.
- i_reg_ie  in  REGNO  one-hot destination register enable (all-zero = no write).
- i_mem_access  in  1  result is a memory operation.
- i_mem_we  in  1  memory operation is a store.
- o_mem_req  out  1  bus request, registered.
- o_mem_we  out  1  bus write strobe, valid while o_mem_req=1.
- o_mem_addr  out  RW  bus address.
- o_mem_data  out  RW  bus write data.
- i_mem_data  in  RW  bus read data, valid with i_mem_ack.
- i_mem_ack  in  1  bus completion; sampled only while o_mem_req=1.
- o_reg_ie  out  REGNO  register-file write enable; a one-cycle pulse.
- o_reg_data  out  RW  register-file write data.
- o_bus_err  out  1  one-cycle pulse on bus timeout (constant 0 without the option).

Behaviour:
- Reset: asynchronous, active-high. Clock i_clk, reset i_rst.
  - State returns to IDLE.
  - o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0.
  - o_reg_ie=0, o_reg_data=0, o_bus_err=0, timeout counter=0.
  - Asserting reset mid-transaction abandons the transaction; no register write occurs.
- Acceptance: a transfer occurs when i_submit & o_ready. i_submit while o_ready=0 is ignored; execute never does this.
- Default every cycle: o_reg_ie=0 and o_bus_err=0, unless set by a rule below.
- IDLE, accept with i_mem_access=0:
  - Next cycle: o_reg_ie=i_reg_ie and o_reg_data=i_data (latency 1).
  - Stay in IDLE, so back-to-back accepts give one write per cycle.
- IDLE, accept with i_mem_access=1:
  - Latch i_addr -> o_mem_addr, i_data -> o_mem_data, i_mem_we -> o_mem_we, and i_reg_ie into an internal register.
  - Next cycle o_mem_req=1; go to BUS. No register write is issued for the memory op itself.
- BUS:
  - o_ready=0. o_mem_req, o_mem_addr, o_mem_data and o_mem_we are held stable until ack.
  - On i_mem_ack=1: next cycle o_mem_req=0 and state is IDLE.
    - Load (o_mem_we=0): that same next cycle, o_reg_ie=latched reg_ie and o_reg_data=i_mem_data.
    - Store: no register write, even if the latched reg_ie is nonzero.
  - Minimum memory-op occupancy is 2 cycles: req issue, then ack in the first BUS cycle.
- i_mem_ack while o_mem_req=0 is ignored, and is not remembered for a later request.
- A load writeback pulse and o_ready=1 coincide in the first cycle back in IDLE. An accept in that cycle is legal; its own writeback appears the following cycle.
- o_mem_addr, o_mem_data and o_mem_we keep their last values after ack; they change only on the next memory accept.

Optional Feature:
- Macro: MEMWB_BUS_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT with no ack: next cycle o_mem_req=0, o_bus_err=1 for one cycle, no register write, state IDLE.
  - An ack in the same cycle as the limit takes precedence: normal completion, no error.
- Not defined: BUS waits indefinitely for ack; the counter logic is absent and o_bus_err is tied to 0.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle -> all outputs 0 immediately, o_ready=1. Repeat with a load in BUS -> o_mem_req drops, no o_reg_ie pulse follows.
- ALU result: submit i_data=16'h1234, i_reg_ie=8'h04, i_mem_access=0 -> next cycle o_reg_ie=8'h04, o_reg_data=16'h1234; following cycle o_reg_ie=0.
- Load: submit i_addr=16'h0040, i_reg_ie=8'h02, mem_access=1, we=0; ack with i_mem_data=16'hBEEF 3 cycles after req -> o_ready low for 4 cycles; one pulse o_reg_ie=8'h02, o_reg_data=16'hBEEF in the cycle after ack.
- Store: submit addr 16'h0010, data 16'h00AA, we=1, reg_ie=8'h01; ack immediately -> o_mem_we=1, o_mem_data=16'h00AA during req; no o_reg_ie pulse; o_ready back after 2 cycles.
- Back-to-back: 4 consecutive ALU submits, then a load, then an ALU submit the cycle o_ready returns -> writes in order, one per cycle; load and ALU writebacks on consecutive cycles; stray ack in IDLE has no effect.
- Timeout (MEMWB_BUS_TIMEOUT_EN, TIMEOUT=4): load with no ack -> o_mem_req drops after 4 BUS cycles, o_bus_err pulses once, no register write. Ack in exactly the 4th BUS cycle -> normal writeback, o_bus_err=0.
